// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared widths and writeback request type
package rf_wb_arbiter_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small synchronous FIFO of writeback requests
module wb_fifo
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  wb_req_t wr_data,
   input  logic    pop,
   output wb_req_t rd_data,
   output logic    full,
   output logic    empty
);
   localparam int PW = $clog2(DEPTH);

   wb_req_t        mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [PW:0]    count;
   logic           do_push, do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // a full FIFO may still take a push when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write port arbiter with pending-write scoreboard
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4,
   parameter int ZERO_PROTECT = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  a_valid_i,
   input  logic [REG_ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0]     a_data_i,
   input  logic                  b_valid_i,
   output logic                  b_ready_o,
   input  logic [REG_ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0]     b_data_i,
   input  logic                  sb_set_i,
   input  logic [REG_ADDR_W-1:0] sb_addr_i,
   input  logic [REG_ADDR_W-1:0] rs_chk_i,
   input  logic [REG_ADDR_W-1:0] rt_chk_i,
   input  logic [REG_ADDR_W-1:0] rd_chk_i,
   output logic                  hazard_o,
   output logic                  stall_o,
   output logic                  RegWrite_o,
   output logic [REG_ADDR_W-1:0] RDaddr_o,
   output logic [DATA_W-1:0]     RDdata_o
);
   localparam int SW = $clog2(STARVE_LIMIT) + 1;
   localparam bit ZP = (ZERO_PROTECT != 0);

   wb_req_t             push_req, head;
   logic                full, empty, push, pop;
   logic [SW-1:0]       starve, starve_next;
   logic [NUM_REGS-1:0] pending, set_mask, clr_mask;

   assign push_req.addr = b_addr_i;
   assign push_req.data = b_data_i;
   assign b_ready_o     = !full;
   assign push          = b_valid_i && b_ready_o;
   // empty is registered, so a result pushed into an empty FIFO pops next cycle at the earliest
   assign pop           = !a_valid_i && !empty;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .push    (push),
      .wr_data (push_req),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (sb_set_i && sb_addr_i != '0) set_mask[sb_addr_i] = 1'b1;
      if (pop) clr_mask[head.addr] = 1'b1;
   end

   assign hazard_o = pending[rs_chk_i] | pending[rt_chk_i] | pending[rd_chk_i];

   always_comb begin
      starve_next = starve;
      if (empty || pop)
         starve_next = '0;
      else if (a_valid_i && starve < SW'(STARVE_LIMIT - 1))
         starve_next = starve + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         RegWrite_o <= 1'b0;
         RDaddr_o   <= '0;
         RDdata_o   <= '0;
         stall_o    <= 1'b0;
         starve     <= '0;
         pending    <= '0;
      end else begin
         if (a_valid_i) begin
            RegWrite_o <= !(ZP && a_addr_i == '0);
            RDaddr_o   <= a_addr_i;
            RDdata_o   <= a_data_i;
         end else if (pop) begin
            RegWrite_o <= !(ZP && head.addr == '0);
            RDaddr_o   <= head.addr;
            RDdata_o   <= head.data;
         end else begin
            RegWrite_o <= 1'b0;
         end
         starve  <= starve_next;
         stall_o <= (starve_next >= SW'(STARVE_LIMIT - 1));
         pending <= (pending & ~clr_mask) | set_mask;
      end
   end

   a_after_stall: assert property (@(posedge clk_i) disable iff (!rst_i) stall_o |-> !a_valid_i);
   sb_double_set: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(sb_set_i && pending[sb_addr_i] && !clr_mask[sb_addr_i]));
endmodule
